// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory between the fetch and load/store ports, one transaction at a time
module riscv_mem_arbiter #(
    parameter int BUS_WIDTH      = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [BUS_WIDTH-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BUS_WIDTH-1:0] d_addr,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    output logic                 bus_err,
    output logic                 m_req,
    output logic                 m_we,
    output logic [BUS_WIDTH-1:0] m_addr,
    output logic [BUS_WIDTH-1:0] m_wdata,
    input  logic                 m_gnt,
    input  logic                 m_rvalid,
    input  logic [BUS_WIDTH-1:0] m_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] NOP = BUS_WIDTH'(32'h0000_0033);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic                 i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [BUS_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                 bus_err_q, bus_err_d;
    logic                 m_req_q, m_req_d, m_we_q, m_we_d;
    logic [BUS_WIDTH-1:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic                 sel_d, done, timeout;

    // owner 1 = data port; data wins unless the fetch has starved for STARVE_LIMIT rounds
    assign sel_d = d_req && !(i_req && starve_cnt_q == STARVE_MAX);

    // next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        i_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        bus_err_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        done         = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_d) begin
                    owner_d      = 1'b1;
                    d_gnt_d      = 1'b1;
                    m_req_d      = 1'b1;
                    m_we_d       = d_we;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_wdata;
                    state_d      = REQ;
                    starve_cnt_d = !i_req ? '0 : (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + SW'(1);
                end else if (i_req) begin
                    owner_d      = 1'b0;
                    i_gnt_d      = 1'b1;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = i_addr;
                    m_wdata_d    = '0;
                    state_d      = REQ;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end
            REQ: begin
                if (m_gnt) begin
                    m_req_d   = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = WAIT;
                    done      = m_rvalid;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    done = 1'b1;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    timeout = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (done || timeout) begin
            state_d   = IDLE;
            bus_err_d = timeout;
            if (owner_q) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = (timeout || m_we_q) ? '0 : m_rdata;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = timeout ? NOP : m_rdata;
            end
        end
    end

    // state and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            bus_err_q    <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            i_gnt_q      <= i_gnt_d;
            d_gnt_q      <= d_gnt_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign i_gnt    = i_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_gnt    = d_gnt_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign bus_err  = bus_err_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench with a behavioural memory for the fetch/data memory arbiter
module tb_riscv_mem_arbiter;
    localparam int W   = 32;
    localparam int SL  = 4;
    localparam int TMO = 255;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req, d_req, d_we;
    logic [W-1:0] i_addr, d_addr, d_wdata;
    logic         i_gnt, i_rvalid, d_gnt, d_rvalid, bus_err;
    logic [W-1:0] i_rdata, d_rdata;
    logic         m_req, m_we, m_gnt, m_rvalid;
    logic [W-1:0] m_addr, m_wdata, m_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int i_gnt_n = 0, d_gnt_n = 0, i_rv_n = 0, d_rv_n = 0;
    int last_rise = -1, min_gap = 1000;
    string glog = "";
    exp_t iq[$];
    exp_t dq[$];

    int           gnt_delay = 0;
    int           gnt_wait = 0;
    bit           mute = 1'b0;
    logic         stale = 1'b0;
    logic         rsp_v = 1'b0;
    logic [W-1:0] rsp_d = '0;
    logic [W-1:0] mem [0:255];
    bit           mem_wr [0:255];
    logic [W-1:0] ref_mem [0:255];
    bit           ref_wr [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_mem_arbiter #(.BUS_WIDTH(W), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .bus_err(bus_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    function automatic logic [W-1:0] dflt(input logic [W-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
    endfunction

    // memory: grant after gnt_delay cycles of m_req, respond one cycle after grant unless muted
    assign m_gnt    = m_req && (gnt_wait >= gnt_delay);
    assign m_rvalid = rsp_v | stale;
    assign m_rdata  = rsp_v ? rsp_d : 32'hBAD0_0BAD;

    always @(posedge clk) begin
        gnt_wait <= (m_req && !m_gnt) ? gnt_wait + 1 : 0;
        rsp_v    <= 1'b0;
        if (m_req && m_gnt && !mute) begin
            rsp_v <= 1'b1;
            if (m_we) begin
                mem[m_addr[9:2]]    <= m_wdata;
                mem_wr[m_addr[9:2]] <= 1'b1;
                rsp_d               <= 32'hFFFF_FFFF;
            end else begin
                rsp_d <= mem_wr[m_addr[9:2]] ? mem[m_addr[9:2]] : dflt(m_addr);
            end
        end
    end

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : dflt(a);
    endfunction

    task automatic monitor();
        exp_t e;
        bit   prev_m = 1'b0;
        forever begin
            @(negedge clk);
            if (i_gnt === 1'b1) begin i_gnt_n++; glog = {glog, "I"}; end
            if (d_gnt === 1'b1) begin d_gnt_n++; glog = {glog, "D"}; end
            if (i_rvalid === 1'b1) begin
                i_rv_n++;
                n_cmp++;
                if (iq.size() == 0) begin
                    $display("FAIL i_resp: unexpected i_rvalid data=%h err=%b", i_rdata, bus_err);
                    n_err++;
                end else begin
                    e = iq.pop_front();
                    if (i_rdata !== e.data || bus_err !== e.err) begin
                        $display("FAIL i_resp: got data=%h err=%b, want data=%h err=%b", i_rdata, bus_err, e.data, e.err);
                        n_err++;
                    end
                end
            end
            if (d_rvalid === 1'b1) begin
                d_rv_n++;
                n_cmp++;
                if (dq.size() == 0) begin
                    $display("FAIL d_resp: unexpected d_rvalid data=%h err=%b", d_rdata, bus_err);
                    n_err++;
                end else begin
                    e = dq.pop_front();
                    if (d_rdata !== e.data || bus_err !== e.err) begin
                        $display("FAIL d_resp: got data=%h err=%b, want data=%h err=%b", d_rdata, bus_err, e.data, e.err);
                        n_err++;
                    end
                end
            end
            if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid) || (bus_err && !i_rvalid && !d_rvalid)) begin
                n_cmp++;
                n_err++;
                $display("FAIL exclusive: gnt=%b%b rvalid=%b%b bus_err=%b", i_gnt, d_gnt, i_rvalid, d_rvalid, bus_err);
            end
            if (m_req === 1'b1 && !prev_m) begin
                if (last_rise >= 0 && cyc - last_rise < min_gap) min_gap = cyc - last_rise;
                last_rise = cyc;
            end
            prev_m = (m_req === 1'b1);
        end
    endtask

    task automatic do_i(input logic [W-1:0] a);
        exp_t e;
        bit   got = 1'b0;
        e.data = ref_rd(a);
        e.err  = 1'b0;
        iq.push_back(e);
        i_req  = 1'b1;
        i_addr = a;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (i_gnt === 1'b1) begin got = 1'b1; break; end
        end
        n_cmp++;
        if (!got) begin
            $display("FAIL i_gnt_wait: no grant for addr %h", a);
            n_err++;
        end else if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== a) begin
            $display("FAIL i_mreq: m_req=%b m_we=%b m_addr=%h, want 1 0 %h", m_req, m_we, m_addr, a);
            n_err++;
        end
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd, input logic err);
        exp_t e;
        bit   got = 1'b0;
        e.data = (we || err) ? '0 : ref_rd(a);
        e.err  = err;
        dq.push_back(e);
        if (we) begin ref_mem[a[9:2]] = wd; ref_wr[a[9:2]] = 1'b1; end
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (d_gnt === 1'b1) begin got = 1'b1; break; end
        end
        n_cmp++;
        if (!got) begin
            $display("FAIL d_gnt_wait: no grant for addr %h", a);
            n_err++;
        end else if (m_req !== 1'b1 || m_we !== we || m_addr !== a || (we && m_wdata !== wd)) begin
            $display("FAIL d_mreq: m_req=%b m_we=%b m_addr=%h m_wdata=%h, want 1 %b %h %h", m_req, m_we, m_addr, m_wdata, we, a, wd);
            n_err++;
        end
        @(posedge clk);
        #1 d_req = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (iq.size() == 0 && dq.size() == 0) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            $display("FAIL %s_drain: %0d fetch and %0d data responses outstanding, want 0", nm, iq.size(), dq.size());
            n_err++;
            iq.delete();
            dq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, bus_err, m_req, m_we, m_addr, m_wdata} !== '0) begin
            $display("FAIL reset_outputs: i_gnt=%b d_gnt=%b m_req=%b m_addr=%h i_rdata=%h d_rdata=%h, want all 0", i_gnt, d_gnt, m_req, m_addr, i_rdata, d_rdata);
            n_err++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fetch();
        int ig = i_gnt_n, dg = d_gnt_n, ir = i_rv_n, dr = d_rv_n;
        do_i(32'h10);
        wait_drain("fetch");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (i_gnt_n - ig != 1 || i_rv_n - ir != 1) begin
            $display("FAIL fetch_pulses: i_gnt=%0d i_rvalid=%0d, want 1 1", i_gnt_n - ig, i_rv_n - ir);
            n_err++;
        end
        n_cmp++;
        if (d_gnt_n != dg || d_rv_n != dr) begin
            $display("FAIL fetch_d_quiet: d_gnt=%0d d_rvalid=%0d, want 0 0", d_gnt_n - dg, d_rv_n - dr);
            n_err++;
        end
        n_cmp++;
        if (i_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL fetch_hold: i_rdata=%h, want deadbeef", i_rdata);
            n_err++;
        end
    endtask

    task automatic test_priority();
        glog = "";
        fork
            do_d(1'b1, 32'h40, 32'h55, 1'b0);
            do_i(32'h20);
        join
        wait_drain("priority");
        n_cmp++;
        if (glog != "DI") begin
            $display("FAIL priority_order: grants %s, want DI", glog);
            n_err++;
        end
        n_cmp++;
        if (d_rdata !== '0) begin
            $display("FAIL store_ack_data: d_rdata=%h, want 0", d_rdata);
            n_err++;
        end
    endtask

    task automatic test_starvation();
        glog = "";
        fork
            for (int k = 0; k < 8; k++) do_d(1'b0, 32'h200 + 32'(4 * k), '0, 1'b0);
            do_i(32'h100);
        join
        wait_drain("starve");
        n_cmp++;
        if (glog != "DDDDIDDDD") begin
            $display("FAIL starve_order: grants %s, want DDDDIDDDD", glog);
            n_err++;
        end
    endtask

    task automatic test_gnt_delay();
        int dg = d_gnt_n, dr = d_rv_n, hi = 0;
        bit stable = 1'b1;
        gnt_delay = 3;
        fork
            do_d(1'b0, 32'h80, '0, 1'b0);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (m_req === 1'b1) begin
                    hi++;
                    if (m_addr !== 32'h80 || m_we !== 1'b0) stable = 1'b0;
                end else if (hi > 0) break;
            end
        join
        wait_drain("gnt_delay");
        gnt_delay = 0;
        n_cmp++;
        if (hi != 4 || !stable) begin
            $display("FAIL gnt_delay_mreq: m_req high %0d cycles stable=%b, want 4 1", hi, stable);
            n_err++;
        end
        n_cmp++;
        if (d_gnt_n - dg != 1 || d_rv_n - dr != 1) begin
            $display("FAIL gnt_delay_pulses: d_gnt=%0d d_rvalid=%0d, want 1 1", d_gnt_n - dg, d_rv_n - dr);
            n_err++;
        end
    endtask

    task automatic test_timeout();
        int c0 = -1, c1 = -1, ir, dr;
        mute = 1'b1;
        fork
            do_d(1'b0, 32'hC0, '0, 1'b1);
            begin
                for (int k = 0; k < 30 && c0 < 0; k++) begin
                    @(negedge clk);
                    if (m_req === 1'b1 && m_gnt === 1'b1) c0 = cyc;
                end
                for (int k = 0; k < TMO + 30 && c0 >= 0 && c1 < 0; k++) begin
                    @(negedge clk);
                    if (d_rvalid === 1'b1) c1 = cyc;
                end
            end
        join
        wait_drain("timeout");
        n_cmp++;
        if (c0 < 0 || c1 < 0 || c1 - c0 != TMO + 1) begin
            $display("FAIL timeout_latency: gnt cycle %0d rvalid cycle %0d, want distance %0d", c0, c1, TMO + 1);
            n_err++;
        end
        ir = i_rv_n;
        dr = d_rv_n;
        @(posedge clk);
        #1 stale = 1'b1;
        @(posedge clk);
        #1 stale = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (i_rv_n != ir || d_rv_n != dr) begin
            $display("FAIL late_rvalid: i_rvalid=%0d d_rvalid=%0d extra, want 0 0", i_rv_n - ir, d_rv_n - dr);
            n_err++;
        end
        mute = 1'b0;
        @(posedge clk);
        #1 do_d(1'b0, 32'hC0, '0, 1'b0);
        wait_drain("after_timeout");
        n_cmp++;
        if (d_rv_n - dr != 1) begin
            $display("FAIL after_timeout: d_rvalid=%0d, want 1", d_rv_n - dr);
            n_err++;
        end
    endtask

    task automatic test_reset_in_wait();
        int ir, dr;
        mute = 1'b1;
        do_d(1'b0, 32'hE0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        dq.delete();
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, bus_err, m_req, m_we, m_addr, m_wdata} !== '0) begin
            $display("FAIL reset_wait_outputs: m_req=%b m_addr=%h d_rvalid=%b i_rdata=%h d_rdata=%h, want all 0", m_req, m_addr, d_rvalid, i_rdata, d_rdata);
            n_err++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ir = i_rv_n;
        dr = d_rv_n;
        stale = 1'b1;
        @(posedge clk);
        #1 stale = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (i_rv_n != ir || d_rv_n != dr) begin
            $display("FAIL reset_stale: i_rvalid=%0d d_rvalid=%0d extra, want 0 0", i_rv_n - ir, d_rv_n - dr);
            n_err++;
        end
        mute = 1'b0;
        @(posedge clk);
        #1 do_i(32'h30C);
        wait_drain("reset_recover");
        n_cmp++;
        if (i_rv_n - ir != 1) begin
            $display("FAIL reset_recover: i_rvalid=%0d, want 1", i_rv_n - ir);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int ig = i_gnt_n, dg = d_gnt_n;
        min_gap   = 1000;
        last_rise = -1;
        fork
            begin
                do_i(32'h300);
                do_i(32'h304);
                do_i(32'h308);
            end
            begin
                do_d(1'b1, 32'h40, 32'h1234_5678, 1'b0);
                do_d(1'b0, 32'h40, '0, 1'b0);
                do_d(1'b0, 32'h44, '0, 1'b0);
            end
        join
        wait_drain("b2b");
        n_cmp++;
        if (i_gnt_n - ig != 3 || d_gnt_n - dg != 3) begin
            $display("FAIL b2b_grants: i_gnt=%0d d_gnt=%0d, want 3 3", i_gnt_n - ig, d_gnt_n - dg);
            n_err++;
        end
        n_cmp++;
        if (min_gap != 3) begin
            $display("FAIL b2b_spacing: min m_req spacing %0d cycles, want 3", min_gap);
            n_err++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        fork
            monitor();
        join_none
        test_reset();
        @(posedge clk);
        #1 test_fetch();
        @(posedge clk);
        #1 test_priority();
        @(posedge clk);
        #1 test_starvation();
        @(posedge clk);
        #1 test_gnt_delay();
        @(posedge clk);
        #1 test_timeout();
        @(posedge clk);
        #1 test_reset_in_wait();
        @(posedge clk);
        #1 test_back_to_back();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
